// File: rtl/verifla_uart_pkg.sv
// Shared definitions for the VeriFLA UART transmitter: state encoding,
// idle line level and default frame format.
package verifla_uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE         = 1'b1;
    localparam int   DEFAULT_DATA_BITS = 8;
    localparam int   DEFAULT_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_of_verifla.sv
// UART transmitter with a one-entry holding register, paced by an external baud tick.
// Optional parity bit (and PARITY_ODD parameter) when VERIFLA_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+----------------------------------------------------------
// TX_IDLE   | line idle high, waiting for a tick with the hold register full
// TX_START  | start bit (0) on the line
// TX_DATA   | payload bits, LSB first; cnt_q counts bits already sent
// TX_PARITY | parity bit on the line (parity build only)
// TX_STOP   | stop bit(s) high; cnt_q counts stop periods elapsed
module uart_tx_of_verifla
    import verifla_uart_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int STOP_BITS    = DEFAULT_STOP_BITS,
    parameter int BIT_CNT_SIZE = 4
`ifdef VERIFLA_TX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam logic [BIT_CNT_SIZE-1:0] CNT_ONE  = BIT_CNT_SIZE'(1);
    localparam logic [BIT_CNT_SIZE-1:0] CNT_DATA = BIT_CNT_SIZE'(DATA_BITS);
    localparam logic [BIT_CNT_SIZE-1:0] CNT_STOP = BIT_CNT_SIZE'(STOP_BITS);

    tx_state_e               state_q, state_d;
    logic [BIT_CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic [DATA_BITS-1:0]    hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    txd_q, txd_d;
    logic                    load_frame;
`ifdef VERIFLA_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign tx_ready = ~hold_full_q;
    assign txd      = txd_q;
    assign tx_busy  = (state_q != TX_IDLE) || hold_full_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= TX_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= LINE_IDLE;
`ifdef VERIFLA_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
`ifdef VERIFLA_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txd_d       = txd_q;
        load_frame  = 1'b0;
`ifdef VERIFLA_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        // Cannot collide with load_frame: tx_ready is low whenever hold is full.
        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (baud_tick) begin
            case (state_q)
                TX_IDLE: begin
                    txd_d      = LINE_IDLE;
                    load_frame = hold_full_q;
                end
                TX_START: begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_ONE;
                    state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (cnt_q < CNT_DATA) begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
`ifdef VERIFLA_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = TX_PARITY;
`else
                        txd_d   = LINE_IDLE;
                        cnt_d   = CNT_ONE;
                        state_d = TX_STOP;
`endif
                    end
                end
`ifdef VERIFLA_TX_PARITY_EN
                TX_PARITY: begin
                    txd_d   = LINE_IDLE;
                    cnt_d   = CNT_ONE;
                    state_d = TX_STOP;
                end
`endif
                TX_STOP: begin
                    if (cnt_q < CNT_STOP) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (hold_full_q) begin
                        load_frame = 1'b1;
                    end else begin
                        txd_d   = LINE_IDLE;
                        cnt_d   = '0;
                        state_d = TX_IDLE;
                    end
                end
                default: begin
                    txd_d   = LINE_IDLE;
                    state_d = TX_IDLE;
                end
            endcase

            // The start bit goes out on the same tick that empties hold.
            if (load_frame) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                txd_d       = 1'b0;
                state_d     = TX_START;
`ifdef VERIFLA_TX_PARITY_EN
                parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
`endif
            end
        end
    end

endmodule
